// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the instruction fetch sequencer
package fetch_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0] DEF_LAST_ADDR = 16'h001C;
  localparam logic [ADDR_W-1:0] DEF_PC_STEP   = 16'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  // Instructions are 16-bit words, so redirect targets are forced even.
  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr);
    return addr & ~{{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - control, memory and decode signals of the fetch sequencer
interface fetch_sequencer_if;
  import fetch_pkg::*;

  logic                start;
  logic [ADDR_W-1:0]   pc_out;
  logic [INSTR_W-1:0]  instr_in;
  logic [INSTR_W-1:0]  instr_out;
  logic [ADDR_W-1:0]   instr_pc;
  logic                instr_valid;
  logic                instr_ready;
  logic                branch_valid;
  logic [ADDR_W-1:0]   branch_target;
  logic                done;
  logic                fault;

  modport master (
    input  start, instr_in, instr_ready, branch_valid, branch_target,
    output pc_out, instr_out, instr_pc, instr_valid, done, fault
  );

  modport slave (
    output start, instr_in, instr_ready, branch_valid, branch_target,
    input  pc_out, instr_out, instr_pc, instr_valid, done, fault
  );

endinterface

// File: rtl/fetch_ir_buffer.sv
// rtl/fetch_ir_buffer.sv - one-entry instruction/pc holding register with valid and flush
module fetch_ir_buffer
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;
  logic               valid_q;

  // Flush only drops valid; stale data is harmless once invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - sequential instruction fetch FSM with stall, redirect and halt
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] LAST_ADDR = DEF_LAST_ADDR,
  parameter logic [ADDR_W-1:0] PC_STEP   = DEF_PC_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_sequencer_if.master bus
);

  fetch_state_e       state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic               done_q;
  logic               fault_q;

  logic [INSTR_W-1:0] buf_instr;
  logic [ADDR_W-1:0]  buf_pc;
  logic               buf_valid;

  logic [ADDR_W-1:0]  redirect_pc;
  logic               transfer;
  logic               at_last;
  logic               redirect;
  logic               redirect_bad;
  logic               capture;
  logic               drain_done;
  logic               flush;

  // Redirect outranks both capture and drain completion.
  always_comb begin
    redirect_pc  = align_addr(bus.branch_target);
    transfer     = buf_valid & bus.instr_ready;
    at_last      = (pc_q == LAST_ADDR);
    redirect     = bus.branch_valid && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    redirect_bad = (redirect_pc > LAST_ADDR);
    capture      = (state_q == ST_RUN) && !redirect && (!buf_valid || transfer);
    drain_done   = (state_q == ST_DRAIN) && !redirect && transfer;
    flush        = redirect || drain_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (redirect) begin
            if (redirect_bad) begin
              state_q <= ST_HALTED;
              fault_q <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              pc_q    <= redirect_pc;
            end
          end else if (capture) begin
            // The last word parks pc; DRAIN waits for decode to take it.
            if (at_last) state_q <= ST_DRAIN;
            else         pc_q    <= pc_q + PC_STEP;
          end else if (drain_done) begin
            state_q <= ST_HALTED;
            done_q  <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (bus.start) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  fetch_ir_buffer u_ir_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (capture),
    .flush_i (flush),
    .instr_i (bus.instr_in),
    .pc_i    (pc_q),
    .instr_o (buf_instr),
    .pc_o    (buf_pc),
    .valid_o (buf_valid)
  );

  assign bus.pc_out      = pc_q;
  assign bus.instr_out   = buf_instr;
  assign bus.instr_pc    = buf_pc;
  assign bus.instr_valid = buf_valid;
  assign bus.done        = done_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory model: word k holds 16'hA000 + k.
  assign bus.instr_in = 16'hA000 + {1'b0, bus.pc_out[15:1]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pc_out"},      bus.pc_out,               16'h0000);
    chk({tag, ".instr_out"},   bus.instr_out,            16'h0000);
    chk({tag, ".instr_pc"},    bus.instr_pc,             16'h0000);
    chk({tag, ".instr_valid"}, {15'd0, bus.instr_valid}, 16'h0000);
    chk({tag, ".done"},        {15'd0, bus.done},        16'h0000);
    chk({tag, ".fault"},       {15'd0, bus.fault},       16'h0000);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b1;
    bus.start         = 1'b0;
    bus.instr_ready   = 1'b1;
    bus.branch_valid  = 1'b0;
    bus.branch_target = 16'h0000;

    #1 rst_n = 1'b0;
    #2;
    chk_all_zero("reset");

    // Full program run with decode always ready
    tick();
    rst_n     = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("latency_n1_valid", {15'd0, bus.instr_valid}, 16'h0000);
    tick();
    for (int k = 0; k < 15; k++) begin
      chk("seq.instr_valid", {15'd0, bus.instr_valid}, 16'h0001);
      chk("seq.instr_out",   bus.instr_out, 16'hA000 + 16'(k));
      chk("seq.instr_pc",    bus.instr_pc,  16'(2 * k));
      tick();
    end
    chk("seq_end.done",        {15'd0, bus.done},        16'h0001);
    chk("seq_end.instr_valid", {15'd0, bus.instr_valid}, 16'h0000);
    chk("seq_end.fault",       {15'd0, bus.fault},       16'h0000);

    // Restart from HALTED, then stall while 0x0004 is buffered
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("restart.done", {15'd0, bus.done}, 16'h0000);
    tick();
    chk("restart.instr_pc", bus.instr_pc, 16'h0000);
    tick();
    tick();
    chk("stall_pre.instr_pc", bus.instr_pc, 16'h0004);
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.instr_pc",  bus.instr_pc,  16'h0004);
      chk("stall.instr_out", bus.instr_out, 16'hA002);
      chk("stall.pc_out",    bus.pc_out,    16'h0006);
      chk("stall.valid",     {15'd0, bus.instr_valid}, 16'h0001);
    end
    bus.instr_ready = 1'b1;
    tick();
    chk("unstall.instr_pc",  bus.instr_pc,  16'h0006);
    chk("unstall.instr_out", bus.instr_out, 16'hA003);

    // Redirect to odd target drops the buffered 0x0008 word
    tick();
    chk("br_pre.instr_pc", bus.instr_pc, 16'h0008);
    bus.branch_valid  = 1'b1;
    bus.branch_target = 16'h0011;
    tick();
    bus.branch_valid = 1'b0;
    chk("br.instr_valid", {15'd0, bus.instr_valid}, 16'h0000);
    chk("br.pc_out",      bus.pc_out, 16'h0010);
    tick();
    chk("br_post.instr_pc",  bus.instr_pc,  16'h0010);
    chk("br_post.instr_out", bus.instr_out, 16'hA008);
    chk("br_post.valid",     {15'd0, bus.instr_valid}, 16'h0001);

    // Redirect on the cycle that captures LAST_ADDR
    repeat (5) tick();
    chk("drain_br_pre.instr_pc", bus.instr_pc, 16'h001A);
    chk("drain_br_pre.pc_out",   bus.pc_out,   16'h001C);
    bus.branch_valid  = 1'b1;
    bus.branch_target = 16'h0002;
    tick();
    bus.branch_valid = 1'b0;
    chk("drain_br.valid",  {15'd0, bus.instr_valid}, 16'h0000);
    chk("drain_br.done",   {15'd0, bus.done},        16'h0000);
    chk("drain_br.pc_out", bus.pc_out, 16'h0002);
    tick();
    chk("drain_br_post.instr_pc", bus.instr_pc, 16'h0002);
    chk("drain_br_post.valid",    {15'd0, bus.instr_valid}, 16'h0001);

    // start while running has no effect
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_in_run.instr_pc", bus.instr_pc, 16'h0004);

    // Out-of-range redirect faults, start clears it
    bus.branch_valid  = 1'b1;
    bus.branch_target = 16'h0020;
    tick();
    bus.branch_valid = 1'b0;
    chk("fault.fault", {15'd0, bus.fault},       16'h0001);
    chk("fault.valid", {15'd0, bus.instr_valid}, 16'h0000);
    chk("fault.done",  {15'd0, bus.done},        16'h0000);
    tick();
    chk("fault_hold.fault", {15'd0, bus.fault},       16'h0001);
    chk("fault_hold.valid", {15'd0, bus.instr_valid}, 16'h0000);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("fault_clr.fault",  {15'd0, bus.fault}, 16'h0000);
    chk("fault_clr.pc_out", bus.pc_out, 16'h0000);
    tick();
    chk("fault_restart.instr_pc",  bus.instr_pc,  16'h0000);
    chk("fault_restart.instr_out", bus.instr_out, 16'hA000);
    chk("fault_restart.valid",     {15'd0, bus.instr_valid}, 16'h0001);

    // Asynchronous reset mid-fetch
    tick();
    chk("async_pre.instr_pc", bus.instr_pc, 16'h0002);
    rst_n = 1'b0;
    #2;
    chk_all_zero("async_reset");
    tick();
    chk_all_zero("async_reset_held");
    rst_n     = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("post_reset.instr_pc",  bus.instr_pc,  16'h0000);
    chk("post_reset.instr_out", bus.instr_out, 16'hA000);
    chk("post_reset.valid",     {15'd0, bus.instr_valid}, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
